// File: rtl/mmio_pkg.sv
// Shared region decode for the MMIO fabric.
package mmio_pkg;

  typedef enum logic [1:0] {REG_RAM, REG_OUT, REG_IN, REG_NONE} region_e;

  localparam int unsigned SEL_RAM = 0;
  localparam int unsigned SEL_OUT = 1;
  localparam int unsigned SEL_IN  = 2;

  function automatic region_e decode(input int unsigned sel);
    case (sel)
      SEL_RAM: return REG_RAM;
      SEL_OUT: return REG_OUT;
      SEL_IN:  return REG_IN;
      default: return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mmio_sync2.sv
// Two-flop synchroniser for one asynchronous input port.
module mmio_sync2 #(
  parameter int W = 16
) (
  input  logic         i_Clock,
  input  logic         i_Reset,
  input  logic [W-1:0] i_D,
  output logic [W-1:0] o_Q
);

  logic [W-1:0] s1_q, s2_q;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= i_D;
      s2_q <= s1_q;
    end
  end

  assign o_Q = s2_q;

endmodule

// File: rtl/mmio_fabric.sv
// CPU bus fabric: RAM / output-register / input-port decode with a uniform
// 1-cycle read latency and a sticky illegal-access flag.
module mmio_fabric
  import mmio_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int RAM_AW = 7,
  parameter int SEL_W  = 4,
  parameter int N_OUT  = 4,
  parameter int N_IN   = 2
) (
  input  logic                    i_Clock,
  input  logic                    i_Reset,
  input  logic [ADDR_W-1:0]       i_Addr,
  input  logic [DATA_W-1:0]       i_WrData,
  input  logic                    i_Wr,
  output logic [DATA_W-1:0]       o_RdData,
  output logic [RAM_AW-1:0]       o_RamAddr,
  output logic [DATA_W-1:0]       o_RamData,
  output logic                    o_RamWren,
  input  logic [DATA_W-1:0]       i_RamQ,
  output logic [N_OUT*DATA_W-1:0] o_Out,
  output logic [N_OUT-1:0]        o_OutStrobe,
  input  logic [N_IN*DATA_W-1:0]  i_In,
  output logic                    o_Err
);

  logic [SEL_W-1:0] sel;
  logic [3:0]       idx;
  region_e          region;
  logic             idx_out_ok;
  logic             wr_out;
  logic             illegal;
  logic             unused_addr;

  assign sel        = i_Addr[ADDR_W-1 -: SEL_W];
  assign idx        = i_Addr[3:0];
  assign region     = decode(32'(sel));
  assign idx_out_ok = ({1'b0, idx} < 5'(N_OUT));
  assign unused_addr = ^i_Addr;

  assign wr_out  = i_Wr && (region == REG_OUT) && idx_out_ok;
  assign illegal = i_Wr && ((region == REG_IN) || (region == REG_NONE) ||
                            ((region == REG_OUT) && !idx_out_ok));

  // RAM path is pure pass-through; reset gates the enable so a write in flight is cancelled.
  assign o_RamAddr = i_Addr[RAM_AW-1:0];
  assign o_RamData = i_WrData;
  assign o_RamWren = i_Wr && (region == REG_RAM) && !i_Reset;

  logic [N_IN-1:0][DATA_W-1:0] in_sync;

  for (genvar p = 0; p < N_IN; p++) begin : g_sync
    mmio_sync2 #(.W(DATA_W)) u_sync (
      .i_Clock (i_Clock),
      .i_Reset (i_Reset),
      .i_D     (i_In[p*DATA_W +: DATA_W]),
      .o_Q     (in_sync[p])
    );
  end

  logic [N_OUT-1:0][DATA_W-1:0] out_q, out_d;
  logic [N_OUT-1:0]             strb_q, strb_d;
  logic [DATA_W-1:0]            rdat_q, rdat_d;
  region_e                      rsel_q;
  logic                         err_q;

  always_comb begin
    out_d  = out_q;
    strb_d = '0;
    rdat_d = '0;
    for (int k = 0; k < N_OUT; k++) begin
      if (wr_out && idx == 4'(k)) begin
        out_d[k]  = i_WrData;
        strb_d[k] = 1'b1;
      end
    end
    // Read mux samples out_q (pre-write), giving read-before-write on a shared edge.
    if (region == REG_OUT) begin
      for (int k = 0; k < N_OUT; k++)
        if (idx == 4'(k)) rdat_d = out_q[k];
    end else if (region == REG_IN) begin
      for (int k = 0; k < N_IN; k++)
        if (idx == 4'(k)) rdat_d = in_sync[k];
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      out_q  <= '0;
      strb_q <= '0;
      rdat_q <= '0;
      rsel_q <= REG_NONE;
      err_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      strb_q <= strb_d;
      rdat_q <= rdat_d;
      rsel_q <= region;
      err_q  <= err_q | illegal;
    end
  end

  assign o_Out       = out_q;
  assign o_OutStrobe = strb_q;
  assign o_Err       = err_q;
  assign o_RdData    = (rsel_q == REG_RAM) ? i_RamQ : rdat_q;

endmodule
